// File: rtl/fir_pkg.sv
// Shared state encoding and default parameters for the FIR coefficient sender.
package fir_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_NTAPS      = 4;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_RST_CYC    = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RESET  = 2'd1,
    ST_LOAD   = 2'd2,
    ST_STREAM = 2'd3
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fir_sample_fifo.sv
// Sample FIFO with show-ahead read data; flush empties it and discards a same-cycle push.
module fir_sample_fifo
  import fir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          wr_data,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr_q];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/fir_coef_sender.sv
// Reloads a FIR filter: holds it in reset, streams the coefficient table, then
// feeds buffered samples (zero-stuffing and flagging underrun when starved).
module fir_coef_sender
  import fir_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NTAPS      = DEF_NTAPS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int RST_CYC    = DEF_RST_CYC
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_we,
  input  logic [$clog2(NTAPS)-1:0]  cfg_addr,
  input  logic [DATA_W-1:0]         cfg_wdata,
  input  logic                      load_start,
  input  logic                      s_valid,
  input  logic [DATA_W-1:0]         s_data,
  output logic                      s_ready,
  output logic                      flt_rst,
  output logic [DATA_W-1:0]         coef_out,
  output logic [DATA_W-1:0]         x_out,
  output logic                      busy,
  output logic                      underrun
);

  localparam int AW    = $clog2(NTAPS);
  localparam int CNT_W = $clog2(max_int(NTAPS, RST_CYC)) + 1;
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   coef_q [NTAPS];
  logic [DATA_W-1:0]   coef_d [NTAPS];
  logic                flt_rst_q, flt_rst_d;
  logic [DATA_W-1:0]   coef_out_q, coef_out_d;
  logic [DATA_W-1:0]   x_out_q, x_out_d;
  logic                busy_q, busy_d;
  logic                underrun_q, underrun_d;
  logic [AW-1:0]       tap_idx;
  logic                cfg_en;

  logic                fifo_push, fifo_pop, fifo_flush;
  logic                fifo_full, fifo_empty;
  logic [DATA_W-1:0]   fifo_rd_data;
  logic [FCW-1:0]      fifo_count;

  fir_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .wr_data (s_data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign s_ready   = (fifo_count != FCW'(FIFO_DEPTH));
  assign fifo_push = s_valid & ~fifo_full;
  assign cfg_en    = cfg_we && (state_q == ST_IDLE || state_q == ST_STREAM);

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      flt_rst_q  <= 1'b1;
      coef_out_q <= '0;
      x_out_q    <= '0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      flt_rst_q  <= flt_rst_d;
      coef_out_q <= coef_out_d;
      x_out_q    <= x_out_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) coef_q[i] <= '0;
    end else begin
      for (int i = 0; i < NTAPS; i++) coef_q[i] <= coef_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NTAPS; i++) begin
      coef_d[i] = (cfg_en && cfg_addr == AW'(i)) ? cfg_wdata : coef_q[i];
    end
  end

  // Next-state logic; cnt tracks cycles within RESET and the tap index within LOAD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_RESET;
          cnt_d   = '0;
        end
      end
      ST_RESET: begin
        if (cnt_q == CNT_W'(RST_CYC - 1)) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOAD: begin
        if (cnt_q == CNT_W'(NTAPS - 1)) begin
          state_d = ST_STREAM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STREAM: begin
        if (load_start) begin
          state_d = ST_RESET;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered values line up with state_q.
  always_comb begin
    tap_idx    = cnt_d[AW-1:0];
    flt_rst_d  = (state_d == ST_IDLE) || (state_d == ST_RESET);
    busy_d     = (state_d == ST_RESET) || (state_d == ST_LOAD);
    coef_out_d = (state_d == ST_LOAD) ? coef_q[tap_idx] : '0;
    fifo_pop   = (state_d == ST_STREAM);
    fifo_flush = load_start && (state_q == ST_STREAM);
    x_out_d    = (state_d == ST_STREAM && !fifo_empty) ? fifo_rd_data : '0;
    underrun_d = underrun_q;
    if (load_start && (state_q == ST_IDLE || state_q == ST_STREAM)) begin
      underrun_d = 1'b0;
    end else if (state_d == ST_STREAM && fifo_empty) begin
      underrun_d = 1'b1;
    end
  end

  assign flt_rst  = flt_rst_q;
  assign coef_out = coef_out_q;
  assign x_out    = x_out_q;
  assign busy     = busy_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_fir_coef_sender.sv
// Directed, table-driven bench for fir_coef_sender with default parameters.
module tb_fir_coef_sender;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic       load_start;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       flt_rst;
  logic [7:0] coef_out;
  logic [7:0] x_out;
  logic       busy;
  logic       underrun;

  int errors = 0;
  int checks = 0;

  fir_coef_sender dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .load_start (load_start),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .flt_rst    (flt_rst),
    .coef_out   (coef_out),
    .x_out      (x_out),
    .busy       (busy),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic       ld;
    logic       sv;
    logic [7:0] sd;
    logic       e_flt;
    logic [7:0] e_coef;
    logic [7:0] e_x;
    logic       e_busy;
    logic       e_und;
    logic       e_rdy;
  } vec_t;

  localparam int NVEC = 36;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic we, input logic [1:0] addr, input logic [7:0] wdata,
                              input logic ld, input logic sv, input logic [7:0] sd,
                              input logic e_flt, input logic [7:0] e_coef, input logic [7:0] e_x,
                              input logic e_busy, input logic e_und, input logic e_rdy);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.ld = ld; v.sv = sv; v.sd = sd;
    v.e_flt = e_flt; v.e_coef = e_coef; v.e_x = e_x;
    v.e_busy = e_busy; v.e_und = e_und; v.e_rdy = e_rdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h, want 0x%02h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_flt, input logic [7:0] e_coef,
                         input logic [7:0] e_x, input logic e_busy, input logic e_und,
                         input logic e_rdy);
    chk({tag, ".flt_rst"},  flt_rst,  e_flt);
    chk({tag, ".coef_out"}, coef_out, e_coef);
    chk({tag, ".x_out"},    x_out,    e_x);
    chk({tag, ".busy"},     busy,     e_busy);
    chk({tag, ".underrun"}, underrun, e_und);
    chk({tag, ".s_ready"},  s_ready,  e_rdy);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    load_start = 1'b0; s_valid = 1'b0; s_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    @(posedge clk);
    #2;
    chk_all("reset_held", 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  task automatic write_coefs();
    for (int i = 0; i < 4; i++) begin
      cfg_we = 1'b1; cfg_addr = 2'(i); cfg_wdata = 8'(8'h11 * (i + 1));
      step();
    end
    clear_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int accepts;
    logic [7:0] k8;

    //              we addr wdata ld sv sd    | flt coef  x     busy und rdy
    vecs[0]  = mk(1, 0, 8'h11, 0, 0, 8'h00,  1, 8'h00, 8'h00, 0, 0, 1);
    vecs[1]  = mk(1, 1, 8'h22, 0, 0, 8'h00,  1, 8'h00, 8'h00, 0, 0, 1);
    vecs[2]  = mk(1, 2, 8'h33, 0, 0, 8'h00,  1, 8'h00, 8'h00, 0, 0, 1);
    vecs[3]  = mk(1, 3, 8'h44, 0, 0, 8'h00,  1, 8'h00, 8'h00, 0, 0, 1);
    vecs[4]  = mk(0, 0, 8'h00, 1, 0, 8'h00,  1, 8'h00, 8'h00, 1, 0, 1);
    vecs[5]  = mk(0, 0, 8'h00, 1, 0, 8'h00,  1, 8'h00, 8'h00, 1, 0, 1);
    vecs[6]  = mk(0, 0, 8'h00, 0, 0, 8'h00,  0, 8'h11, 8'h00, 1, 0, 1);
    vecs[7]  = mk(1, 2, 8'hAA, 1, 0, 8'h00,  0, 8'h22, 8'h00, 1, 0, 1);
    vecs[8]  = mk(0, 0, 8'h00, 0, 1, 8'h05,  0, 8'h33, 8'h00, 1, 0, 1);
    vecs[9]  = mk(0, 0, 8'h00, 0, 1, 8'h06,  0, 8'h44, 8'h00, 1, 0, 1);
    vecs[10] = mk(0, 0, 8'h00, 0, 1, 8'h07,  0, 8'h00, 8'h05, 0, 0, 1);
    vecs[11] = mk(0, 0, 8'h00, 0, 0, 8'h00,  0, 8'h00, 8'h06, 0, 0, 1);
    vecs[12] = mk(0, 0, 8'h00, 0, 0, 8'h00,  0, 8'h00, 8'h07, 0, 0, 1);
    vecs[13] = mk(0, 0, 8'h00, 0, 0, 8'h00,  0, 8'h00, 8'h00, 0, 1, 1);
    vecs[14] = mk(1, 0, 8'h55, 0, 0, 8'h00,  0, 8'h00, 8'h00, 0, 1, 1);
    vecs[15] = mk(0, 0, 8'h00, 1, 1, 8'hEE,  1, 8'h00, 8'h00, 1, 0, 1);
    vecs[16] = mk(0, 0, 8'h00, 0, 1, 8'h21,  1, 8'h00, 8'h00, 1, 0, 1);
    vecs[17] = mk(0, 0, 8'h00, 0, 1, 8'h22,  0, 8'h55, 8'h00, 1, 0, 1);
    vecs[18] = mk(0, 0, 8'h00, 0, 1, 8'h23,  0, 8'h22, 8'h00, 1, 0, 1);
    vecs[19] = mk(0, 0, 8'h00, 0, 1, 8'h24,  0, 8'h33, 8'h00, 1, 0, 1);
    vecs[20] = mk(0, 0, 8'h00, 0, 1, 8'h25,  0, 8'h44, 8'h00, 1, 0, 1);
    vecs[21] = mk(0, 0, 8'h00, 0, 1, 8'h26,  0, 8'h00, 8'h21, 0, 0, 1);
    vecs[22] = mk(0, 0, 8'h00, 0, 0, 8'h00,  0, 8'h00, 8'h22, 0, 0, 1);
    vecs[23] = mk(0, 0, 8'h00, 0, 0, 8'h00,  0, 8'h00, 8'h23, 0, 0, 1);
    vecs[24] = mk(0, 0, 8'h00, 1, 1, 8'h77,  1, 8'h00, 8'h00, 1, 0, 1);
    vecs[25] = mk(0, 0, 8'h00, 0, 0, 8'h00,  1, 8'h00, 8'h00, 1, 0, 1);
    vecs[26] = mk(0, 0, 8'h00, 0, 0, 8'h00,  0, 8'h55, 8'h00, 1, 0, 1);
    vecs[27] = mk(0, 0, 8'h00, 0, 0, 8'h00,  0, 8'h22, 8'h00, 1, 0, 1);
    vecs[28] = mk(0, 0, 8'h00, 0, 0, 8'h00,  0, 8'h33, 8'h00, 1, 0, 1);
    vecs[29] = mk(0, 0, 8'h00, 0, 0, 8'h00,  0, 8'h44, 8'h00, 1, 0, 1);
    vecs[30] = mk(0, 0, 8'h00, 0, 0, 8'h00,  0, 8'h00, 8'h00, 0, 1, 1);
    vecs[31] = mk(0, 0, 8'h00, 0, 1, 8'h05,  0, 8'h00, 8'h00, 0, 1, 1);
    vecs[32] = mk(0, 0, 8'h00, 0, 1, 8'h06,  0, 8'h00, 8'h05, 0, 1, 1);
    vecs[33] = mk(0, 0, 8'h00, 0, 1, 8'h07,  0, 8'h00, 8'h06, 0, 1, 1);
    vecs[34] = mk(0, 0, 8'h00, 0, 0, 8'h00,  0, 8'h00, 8'h07, 0, 1, 1);
    vecs[35] = mk(0, 0, 8'h00, 0, 0, 8'h00,  0, 8'h00, 8'h00, 0, 1, 1);

    do_reset();
    chk_all("after_reset", 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

    // Main table: load, stream, ignored writes/loads, reload with flush.
    for (int i = 0; i < NVEC; i++) begin
      cfg_we = vecs[i].we; cfg_addr = vecs[i].addr; cfg_wdata = vecs[i].wdata;
      load_start = vecs[i].ld; s_valid = vecs[i].sv; s_data = vecs[i].sd;
      step();
      clear_inputs();
      chk_all($sformatf("vec%0d", i), vecs[i].e_flt, vecs[i].e_coef, vecs[i].e_x,
              vecs[i].e_busy, vecs[i].e_und, vecs[i].e_rdy);
      $display("vec %0d: flt=%0b coef=%02h x=%02h busy=%0b und=%0b rdy=%0b",
               i, flt_rst, coef_out, x_out, busy, underrun, s_ready);
    end

    // FIFO fill in IDLE: 8 of 10 offered words accepted, all delivered in order.
    do_reset();
    accepts = 0;
    s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_data = 8'(i + 1);
      if (i == 7) chk("fill.ready_before_full", s_ready, 8'h01);
      if (i == 8) chk("fill.ready_when_full", s_ready, 8'h00);
      if (s_ready) accepts++;
      step();
    end
    s_valid = 1'b0;
    chk("fill.accepts", 8'(accepts), 8'h08);
    $display("fill: accepted %0d words, s_ready=%0b", accepts, s_ready);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int j = 0; j < 5; j++) begin
      step();
      chk($sformatf("fill.hold%0d.x_out", j), x_out, 8'h00);
      chk($sformatf("fill.hold%0d.s_ready", j), s_ready, 8'h00);
    end
    for (int k = 1; k <= 8; k++) begin
      step();
      k8 = 8'(k);
      chk($sformatf("fill.word%0d", k), x_out, k8);
      chk($sformatf("fill.word%0d.underrun", k), underrun, 8'h00);
      $display("fill: stream word %0d x=%02h", k, x_out);
    end
    step();
    chk("fill.drained.x_out", x_out, 8'h00);
    chk("fill.drained.underrun", underrun, 8'h01);

    // Reset asserted during LOAD cycle 2.
    do_reset();
    write_coefs();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    step();
    step();
    chk("midload.k0", coef_out, 8'h11);
    step();
    chk("midload.k1", coef_out, 8'h22);
    step();
    chk("midload.k2", coef_out, 8'h33);
    #2;
    reset = 1'b1;
    #1;
    chk_all("midload.async", 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    step();
    chk_all("midload.held", 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk_all("midload.idle", 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("midload.cleared_k%0d", k), coef_out, 8'h00);
      chk($sformatf("midload.cleared_k%0d.busy", k), busy, 8'h01);
      $display("midload: reload tap %0d coef=%02h", k, coef_out);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
